// File: rtl/lif_pkg.sv
// Shared defaults and helpers for the time-multiplexed LIF neuron array.
package lif_pkg;

    localparam int BETA_DEF        = 224;
    localparam int THRESH_INIT_DEF = 100;
    localparam int THRESH_MIN_DEF  = 32;
    localparam int THRESH_MAX_DEF  = 220;
    localparam int ADAPT_INC_DEF   = 295;
    localparam int ADAPT_DEC_DEF   = 250;
    localparam int REFRACT_DEF     = 2;

    // Unsigned add that clamps to the largest w-bit value instead of wrapping.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b, input int w);
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (65'd1 << w) - 65'd1;
        return (sum > lim) ? lim[63:0] : sum[63:0];
    endfunction

    // Index width for n neurons, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Refractory counter width able to hold the value r.
    function automatic int refract_width(input int r);
        return (r > 0) ? $clog2(r + 1) : 1;
    endfunction

endpackage

// File: rtl/lif_if.sv
// Input beat and result handshake bundle for the LIF neuron array.
interface lif_if #(
    parameter int WIDTH = 8,
    parameter int ID_W  = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [ID_W-1:0]  in_id;
    logic [WIDTH-1:0] in_current;
    logic             adaptive_threshold;
    logic             out_valid;
    logic             out_ready;
    logic [ID_W-1:0]  out_id;
    logic [WIDTH-1:0] out_state;
    logic             out_spike;
    logic [WIDTH-1:0] out_threshold;

    modport master (
        output in_valid, in_id, in_current, adaptive_threshold, out_ready,
        input  in_ready, out_valid, out_id, out_state, out_spike, out_threshold
    );

    modport slave (
        input  in_valid, in_id, in_current, adaptive_threshold, out_ready,
        output in_ready, out_valid, out_id, out_state, out_spike, out_threshold
    );
endinterface

// File: rtl/lif_update.sv
// Combinational next-state for a single neuron: spike test, leaky integration,
// refractory countdown and optional threshold adaptation.
module lif_update
    import lif_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int BETA       = BETA_DEF,
    parameter int THRESH_MIN = THRESH_MIN_DEF,
    parameter int THRESH_MAX = THRESH_MAX_DEF,
    parameter int ADAPT_INC  = ADAPT_INC_DEF,
    parameter int ADAPT_DEC  = ADAPT_DEC_DEF,
    parameter int REFRACT    = REFRACT_DEF,
    parameter int RW         = refract_width(REFRACT_DEF)
) (
    input  logic [WIDTH-1:0] state_i,
    input  logic [WIDTH-1:0] thresh_i,
    input  logic [RW-1:0]    refract_i,
    input  logic [WIDTH-1:0] current_i,
    input  logic             adaptive_i,
    output logic [WIDTH-1:0] state_o,
    output logic [WIDTH-1:0] thresh_o,
    output logic [RW-1:0]    refract_o,
    output logic             spike_o
);

    // Products are wide enough that nothing wraps before the >>8 and the clamps.
    localparam int PW = 2 * WIDTH + 1;

    logic [PW-1:0]    decayProd;
    logic [PW-1:0]    incProd;
    logic [PW-1:0]    decProd;
    logic [PW-1:0]    decayShift;
    logic [PW-1:0]    incShift;
    logic [PW-1:0]    decShift;
    logic [WIDTH-1:0] incClamp;
    logic [WIDTH-1:0] decClamp;
    logic             spikeNow;

    assign decayProd  = PW'(state_i) * PW'(BETA);
    assign incProd    = PW'(thresh_i) * PW'(ADAPT_INC);
    assign decProd    = PW'(thresh_i) * PW'(ADAPT_DEC);
    assign decayShift = decayProd >> 8;
    assign incShift   = incProd >> 8;
    assign decShift   = decProd >> 8;
    assign incClamp   = (incShift > PW'(THRESH_MAX)) ? WIDTH'(THRESH_MAX) : incShift[WIDTH-1:0];
    assign decClamp   = (decShift < PW'(THRESH_MIN)) ? WIDTH'(THRESH_MIN) : decShift[WIDTH-1:0];

    // The spike decision uses the stored state before this beat's update.
    assign spikeNow = (state_i >= thresh_i);
    assign spike_o  = spikeNow;

    // Spike resets and arms the refractory window; refractory beats ignore input.
    always_comb begin
        state_o   = '0;
        thresh_o  = thresh_i;
        refract_o = refract_i;
        if (spikeNow) begin
            refract_o = RW'(REFRACT);
            if (adaptive_i) begin
                thresh_o = incClamp;
            end
        end else if (refract_i != '0) begin
            refract_o = refract_i - RW'(1);
        end else begin
            state_o = WIDTH'(sat_add(64'(current_i), 64'(decayShift), WIDTH));
            if (adaptive_i) begin
                thresh_o = decClamp;
            end
        end
    end

endmodule

// File: rtl/lif_array.sv
// Array of LIF neurons sharing one update datapath; owns per-neuron storage,
// the input/output handshake and the registered result.
module lif_array
    import lif_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int N_NEURONS   = 4,
    parameter int BETA        = BETA_DEF,
    parameter int THRESH_INIT = THRESH_INIT_DEF,
    parameter int THRESH_MIN  = THRESH_MIN_DEF,
    parameter int THRESH_MAX  = THRESH_MAX_DEF,
    parameter int ADAPT_INC   = ADAPT_INC_DEF,
    parameter int ADAPT_DEC   = ADAPT_DEC_DEF,
    parameter int REFRACT     = REFRACT_DEF
) (
    input logic  clk,
    input logic  rst,
    lif_if.slave bus
);

    localparam int ID_W = id_width(N_NEURONS);
    localparam int RW   = refract_width(REFRACT);

    logic [WIDTH-1:0] stateMem_q   [N_NEURONS];
    logic [WIDTH-1:0] threshMem_q  [N_NEURONS];
    logic [RW-1:0]    refractMem_q [N_NEURONS];

    logic             outValid_q;
    logic [ID_W-1:0]  outId_q;
    logic [WIDTH-1:0] outState_q;
    logic             outSpike_q;
    logic [WIDTH-1:0] outThresh_q;

    logic             accept;
    logic             idInRange;
    logic             update;
    logic [ID_W-1:0]  rdIdx;
    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] thresh_d;
    logic [RW-1:0]    refract_d;
    logic             spike_d;

    // A held result blocks new beats unless it is being drained this cycle.
    assign bus.in_ready = !outValid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign idInRange    = 32'(bus.in_id) < 32'(N_NEURONS);
    assign update       = accept && idInRange;
    assign rdIdx        = idInRange ? bus.in_id : '0;

    lif_update #(
        .WIDTH      (WIDTH),
        .BETA       (BETA),
        .THRESH_MIN (THRESH_MIN),
        .THRESH_MAX (THRESH_MAX),
        .ADAPT_INC  (ADAPT_INC),
        .ADAPT_DEC  (ADAPT_DEC),
        .REFRACT    (REFRACT),
        .RW         (RW)
    ) u_update (
        .state_i    (stateMem_q[rdIdx]),
        .thresh_i   (threshMem_q[rdIdx]),
        .refract_i  (refractMem_q[rdIdx]),
        .current_i  (bus.in_current),
        .adaptive_i (bus.adaptive_threshold),
        .state_o    (state_d),
        .thresh_o   (thresh_d),
        .refract_o  (refract_d),
        .spike_o    (spike_d)
    );

    // Per-neuron storage; only the addressed neuron is written on a valid beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < N_NEURONS; n++) begin
                stateMem_q[n]   <= '0;
                threshMem_q[n]  <= WIDTH'(THRESH_INIT);
                refractMem_q[n] <= '0;
            end
        end else if (update) begin
            stateMem_q[rdIdx]   <= state_d;
            threshMem_q[rdIdx]  <= thresh_d;
            refractMem_q[rdIdx] <= refract_d;
        end
    end

    // Result register: load on a valid beat, clear when drained, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outValid_q  <= 1'b0;
            outId_q     <= '0;
            outState_q  <= '0;
            outSpike_q  <= 1'b0;
            outThresh_q <= '0;
        end else if (update) begin
            outValid_q  <= 1'b1;
            outId_q     <= bus.in_id;
            outState_q  <= state_d;
            outSpike_q  <= spike_d;
            outThresh_q <= thresh_d;
        end else if (bus.out_ready) begin
            outValid_q  <= 1'b0;
        end
    end

    assign bus.out_valid     = outValid_q;
    assign bus.out_id        = outId_q;
    assign bus.out_state     = outState_q;
    assign bus.out_spike     = outSpike_q;
    assign bus.out_threshold = outThresh_q;

endmodule

// File: tb/tb_lif_array.sv
// Self-checking bench for lif_array: directed scenarios plus a randomized
// cycle-level run compared against a behavioural neuron model.
module tb_lif_array;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    lif_if #(.WIDTH(8), .ID_W(2)) bus ();
    lif_if #(.WIDTH(8), .ID_W(2)) busSat ();

    lif_array #(.WIDTH(8), .N_NEURONS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    lif_array #(.WIDTH(8), .N_NEURONS(4), .THRESH_INIT(255)) dutSat (
        .clk (clk),
        .rst (rst),
        .bus (busSat)
    );

    int passCount  = 0;
    int checkCount = 0;

    int mState [4];
    int mThr   [4];
    int mRef   [4];
    int expId, expSpike, expState, expThr;

    // Reference model state after reset.
    task automatic modelReset();
        for (int i = 0; i < 4; i++) begin
            mState[i] = 0;
            mThr[i]   = 100;
            mRef[i]   = 0;
        end
    endtask

    // One accepted beat of the leaky integrate-and-fire rules in plain integers.
    task automatic modelStep(input int id, input int cur, input int adapt);
        int spike;
        spike = (mState[id] >= mThr[id]) ? 1 : 0;
        if (spike == 1) begin
            mState[id] = 0;
            mRef[id]   = 2;
            if (adapt != 0) begin
                mThr[id] = (mThr[id] * 295) / 256;
                if (mThr[id] > 220) mThr[id] = 220;
            end
        end else if (mRef[id] > 0) begin
            mState[id] = 0;
            mRef[id]   = mRef[id] - 1;
        end else begin
            mState[id] = cur + (mState[id] * 224) / 256;
            if (mState[id] > 255) mState[id] = 255;
            if (adapt != 0) begin
                mThr[id] = (mThr[id] * 250) / 256;
                if (mThr[id] < 32) mThr[id] = 32;
            end
        end
        expId    = id;
        expSpike = spike;
        expState = mState[id];
        expThr   = mThr[id];
    endtask

    // Present one beat on the main DUT and wait (bounded) for it to be taken.
    task automatic sendBeat(input int id, input int cur, input int adapt);
        bit acc;
        acc = 1'b0;
        bus.in_id              = 2'(id);
        bus.in_current         = 8'(cur);
        bus.adaptive_threshold = adapt[0];
        bus.in_valid           = 1'b1;
        #1;
        for (int c = 0; c < 20 && !acc; c++) begin
            if (bus.in_ready === 1'b1) acc = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (acc) begin
            modelStep(id, cur, adapt);
        end else begin
            checkCount++;
            $display("[TB] FAIL accept_timeout: id %0d not accepted, got in_ready=%b required 1", id, bus.in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_id = '0; bus.in_current = '0;
        bus.adaptive_threshold = 1'b0; bus.out_ready = 1'b1;
        busSat.in_valid = 1'b0; busSat.in_id = '0; busSat.in_current = '0;
        busSat.adaptive_threshold = 1'b0; busSat.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkCount++;
        if ({bus.out_valid, bus.out_id, bus.out_spike, bus.out_state, bus.out_threshold} !== 20'd0)
            $display("[TB] FAIL reset_outputs: got valid=%b id=%0d spike=%b state=%0d thr=%0d required all 0",
                     bus.out_valid, bus.out_id, bus.out_spike, bus.out_state, bus.out_threshold);
        else passCount++;
        checkCount++;
        if (bus.in_ready !== 1'b1)
            $display("[TB] FAIL reset_in_ready: got %b required 1", bus.in_ready);
        else passCount++;
        rst = 1'b0;
        modelReset();
    endtask

    task automatic test_basic();
        sendBeat(0, 50, 0);
        checkCount++;
        if ({bus.out_valid, bus.out_id, bus.out_spike, bus.out_state, bus.out_threshold} !==
            {1'b1, 2'd0, 1'b0, 8'd50, 8'd100})
            $display("[TB] FAIL basic_id0: got valid=%b id=%0d spike=%b state=%0d thr=%0d required 1/0/0/50/100",
                     bus.out_valid, bus.out_id, bus.out_spike, bus.out_state, bus.out_threshold);
        else passCount++;
    endtask

    task automatic test_refractory();
        int expSt [6] = '{60, 112, 0, 0, 0, 60};
        int expSp [6] = '{0, 0, 1, 0, 0, 0};
        for (int i = 0; i < 6; i++) begin
            sendBeat(1, 60, 0);
            checkCount++;
            if (bus.out_id !== 2'd1 || bus.out_spike !== expSp[i][0] || bus.out_state !== 8'(expSt[i]) ||
                bus.out_threshold !== 8'd100)
                $display("[TB] FAIL refract_beat%0d: got id=%0d spike=%b state=%0d thr=%0d required 1/%0d/%0d/100",
                         i, bus.out_id, bus.out_spike, bus.out_state, bus.out_threshold, expSp[i], expSt[i]);
            else passCount++;
        end
    endtask

    task automatic test_adaptive();
        int adp   [6] = '{0, 0, 1, 1, 1, 1};
        int expSt [6] = '{60, 112, 0, 0, 0, 60};
        int expSp [6] = '{0, 0, 1, 0, 0, 0};
        int expTh [6] = '{100, 100, 115, 115, 115, 112};
        for (int i = 0; i < 6; i++) begin
            sendBeat(3, 60, adp[i]);
            checkCount++;
            if (bus.out_id !== 2'd3 || bus.out_spike !== expSp[i][0] || bus.out_state !== 8'(expSt[i]) ||
                bus.out_threshold !== 8'(expTh[i]))
                $display("[TB] FAIL adaptive_beat%0d: got spike=%b state=%0d thr=%0d required %0d/%0d/%0d",
                         i, bus.out_spike, bus.out_state, bus.out_threshold, expSp[i], expSt[i], expTh[i]);
            else passCount++;
        end
    endtask

    task automatic test_saturation();
        int expSt [2] = '{200, 255};
        bit acc;
        for (int i = 0; i < 2; i++) begin
            acc = 1'b0;
            busSat.in_id = 2'd2; busSat.in_current = 8'd200; busSat.in_valid = 1'b1;
            #1;
            for (int c = 0; c < 20 && !acc; c++) begin
                if (busSat.in_ready === 1'b1) acc = 1'b1;
                @(posedge clk);
                #1;
            end
            busSat.in_valid = 1'b0;
            checkCount++;
            if (!acc || busSat.out_valid !== 1'b1 || busSat.out_spike !== 1'b0 ||
                busSat.out_state !== 8'(expSt[i]) || busSat.out_threshold !== 8'd255)
                $display("[TB] FAIL saturate_beat%0d: got valid=%b spike=%b state=%0d thr=%0d required 1/0/%0d/255",
                         i, busSat.out_valid, busSat.out_spike, busSat.out_state, busSat.out_threshold, expSt[i]);
            else passCount++;
        end
    endtask

    task automatic test_backpressure();
        sendBeat(2, 30, 0);
        bus.out_ready  = 1'b0;
        bus.in_id      = 2'd0;
        bus.in_current = 8'd10;
        bus.adaptive_threshold = 1'b0;
        bus.in_valid   = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checkCount++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
                {bus.out_id, bus.out_spike, bus.out_state, bus.out_threshold} !== {2'd2, 1'b0, 8'd30, 8'd100})
                $display("[TB] FAIL stall_cycle%0d: got rdy=%b valid=%b id=%0d state=%0d thr=%0d required 0/1/2/30/100",
                         c, bus.in_ready, bus.out_valid, bus.out_id, bus.out_state, bus.out_threshold);
            else passCount++;
        end
        bus.out_ready = 1'b1;
        #1;
        checkCount++;
        if (bus.in_ready !== 1'b1)
            $display("[TB] FAIL release_ready: got %b required 1", bus.in_ready);
        else passCount++;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        modelStep(0, 10, 0);
        checkCount++;
        if (bus.out_valid !== 1'b1 ||
            {bus.out_id, bus.out_spike, bus.out_state, bus.out_threshold} !== {2'd0, 1'b0, 8'd53, 8'd100})
            $display("[TB] FAIL release_accept: got valid=%b id=%0d state=%0d thr=%0d required 1/0/53/100",
                     bus.out_valid, bus.out_id, bus.out_state, bus.out_threshold);
        else passCount++;
    endtask

    task automatic test_random();
        bit mOutValid;
        logic [18:0] mPay;
        bit vIn, ordy, rdyExp;
        int id, cur, adapt;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        mOutValid = 1'b0;
        mPay      = '0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            vIn   = ($urandom_range(0, 3) != 0);
            id    = int'($urandom_range(0, 3));
            cur   = int'($urandom_range(0, 255));
            adapt = int'($urandom_range(0, 1));
            ordy  = ($urandom_range(0, 3) != 0);
            bus.in_valid = vIn; bus.in_id = 2'(id); bus.in_current = 8'(cur);
            bus.adaptive_threshold = adapt[0]; bus.out_ready = ordy;
            #1;
            rdyExp = !mOutValid || ordy;
            checkCount++;
            if (bus.in_ready !== rdyExp)
                $display("[TB] FAIL rand_in_ready cyc%0d: got %b required %b", cyc, bus.in_ready, rdyExp);
            else passCount++;
            @(posedge clk);
            #1;
            if (vIn && rdyExp) begin
                modelStep(id, cur, adapt);
                mOutValid = 1'b1;
                mPay = {2'(expId), expSpike[0], 8'(expState), 8'(expThr)};
            end else if (ordy) begin
                mOutValid = 1'b0;
            end
            checkCount++;
            if (bus.out_valid !== mOutValid || (mOutValid &&
                {bus.out_id, bus.out_spike, bus.out_state, bus.out_threshold} !== mPay))
                $display("[TB] FAIL rand_out cyc%0d: got valid=%b payload=%h required valid=%b payload=%h",
                         cyc, bus.out_valid, {bus.out_id, bus.out_spike, bus.out_state, bus.out_threshold},
                         mOutValid, mPay);
            else passCount++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    task automatic test_reset_midstream();
        int ids [4] = '{0, 3, 0, 3};
        int curs[4] = '{20, 25, 35, 15};
        for (int i = 0; i < 4; i++) begin
            sendBeat(ids[i], curs[i], 0);
            checkCount++;
            if ({bus.out_id, bus.out_spike, bus.out_state, bus.out_threshold} !==
                {2'(expId), expSpike[0], 8'(expState), 8'(expThr)})
                $display("[TB] FAIL interleave_beat%0d: got id=%0d spike=%b state=%0d thr=%0d required %0d/%0d/%0d/%0d",
                         i, bus.out_id, bus.out_spike, bus.out_state, bus.out_threshold,
                         expId, expSpike, expState, expThr);
            else passCount++;
        end
        #2;
        rst = 1'b1;
        #1;
        checkCount++;
        if ({bus.out_valid, bus.out_id, bus.out_spike, bus.out_state, bus.out_threshold} !== 20'd0)
            $display("[TB] FAIL async_reset: got valid=%b state=%0d thr=%0d required all 0",
                     bus.out_valid, bus.out_state, bus.out_threshold);
        else passCount++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
        checkCount++;
        if (bus.in_ready !== 1'b1)
            $display("[TB] FAIL post_reset_ready: got %b required 1", bus.in_ready);
        else passCount++;
        for (int i = 0; i < 4; i++) begin
            sendBeat(i, 40, 0);
            checkCount++;
            if ({bus.out_valid, bus.out_id, bus.out_spike, bus.out_state, bus.out_threshold} !==
                {1'b1, 2'(i), 1'b0, 8'd40, 8'd100})
                $display("[TB] FAIL restart_id%0d: got valid=%b spike=%b state=%0d thr=%0d required 1/0/40/100",
                         i, bus.out_valid, bus.out_spike, bus.out_state, bus.out_threshold);
            else passCount++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_refractory();
        test_adaptive();
        test_saturation();
        test_backpressure();
        test_random();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
